// File: rtl/control_multiciclo.sv
`default_nettype none
// ============================================================================
// Module  : control_multiciclo
// Brief   : Multi-cycle control FSM sequencing ALU, register bank and unified
//           memory, with memory-ready handshake timeout and illegal-op flag.
// Rev     : 1.0  initial release
// ============================================================================
module control_multiciclo #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opCode,
    input  logic       memReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [2:0] ALUOP,
    output logic       instrDone,
    output logic       illegalOp,
    output logic       memTimeout,
    output logic [3:0] state
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_waitLast = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    localparam logic [5:0] c_opR    = 6'b000000;
    localparam logic [5:0] c_opAddi = 6'b001000;
    localparam logic [5:0] c_opSlti = 6'b001010;
    localparam logic [5:0] c_opAndi = 6'b001100;
    localparam logic [5:0] c_opOri  = 6'b001101;
    localparam logic [5:0] c_opLw   = 6'b100011;
    localparam logic [5:0] c_opSw   = 6'b101011;
    localparam logic [5:0] c_opBeq  = 6'b000100;

    localparam logic [2:0] c_aluFunct = 3'b000;
    localparam logic [2:0] c_aluAdd   = 3'b010;
    localparam logic [2:0] c_aluSub   = 3'b110;
    localparam logic [2:0] c_aluAnd   = 3'b011;
    localparam logic [2:0] c_aluOr    = 3'b001;
    localparam logic [2:0] c_aluSlt   = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_waitCnt;
    logic [5:0]         r_opLatched;
    logic               w_waitCycle;
    logic               w_timeout;

    // Any state that parks on memReady counts toward the timeout.
    assign w_waitCycle = !memReady &&
                         ((r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR));
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_waitCycle && (r_waitCnt == c_waitLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_waitCnt   <= '0;
            r_opLatched <= '0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= (w_waitCycle && !w_timeout) ? r_waitCnt + CNT_W'(1) : '0;
            if (r_state == S_DECODE) begin
                r_opLatched <= opCode;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUsrcA     = 1'b0;
        ALUsrcB     = 2'b00;
        ALUOP       = c_aluFunct;
        instrDone   = 1'b0;
        illegalOp   = 1'b0;
        memTimeout  = 1'b0;
        state       = r_state;

        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUsrcB = 2'b01;
                ALUOP   = c_aluAdd;
                IRWrite = memReady;
                PCWrite = memReady;
                if (memReady) begin
                    w_nextState = S_DECODE;
                end else if (w_timeout) begin
                    memTimeout  = 1'b1;
                    w_nextState = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUsrcB = 2'b11;
                ALUOP   = c_aluAdd;
                case (opCode)
                    c_opR:                                    w_nextState = S_EXEC_R;
                    c_opAddi, c_opSlti, c_opAndi, c_opOri:    w_nextState = S_EXEC_I;
                    c_opLw, c_opSw:                           w_nextState = S_MEM_ADDR;
                    c_opBeq:                                  w_nextState = S_BRANCH;
                    default: begin
                        illegalOp   = 1'b1;
                        w_nextState = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                ALUsrcA     = 1'b1;
                w_nextState = S_WB_ALU;
            end
            S_EXEC_I: begin
                ALUsrcA = 1'b1;
                ALUsrcB = 2'b10;
                case (r_opLatched)
                    c_opSlti: ALUOP = c_aluSlt;
                    c_opAndi: ALUOP = c_aluAnd;
                    c_opOri:  ALUOP = c_aluOr;
                    default:  ALUOP = c_aluAdd;
                endcase
                w_nextState = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                ALUsrcA     = 1'b1;
                ALUsrcB     = 2'b10;
                ALUOP       = c_aluAdd;
                w_nextState = (r_opLatched == c_opSw) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (memReady) begin
                    w_nextState = S_MEM_WB;
                end else if (w_timeout) begin
                    memTimeout  = 1'b1;
                    w_nextState = S_FETCH;
                end
            end
            S_MEM_WB: begin
                RegWrite    = 1'b1;
                MemToReg    = 1'b1;
                instrDone   = 1'b1;
                w_nextState = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (memReady) begin
                    instrDone   = 1'b1;
                    w_nextState = S_FETCH;
                end else if (w_timeout) begin
                    memTimeout  = 1'b1;
                    w_nextState = S_FETCH;
                end
            end
            S_WB_ALU: begin
                RegWrite    = 1'b1;
                RegDst      = (r_opLatched == c_opR);
                instrDone   = 1'b1;
                w_nextState = S_FETCH;
            end
            S_BRANCH: begin
                ALUsrcA     = 1'b1;
                ALUOP       = c_aluSub;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                instrDone   = 1'b1;
                w_nextState = S_FETCH;
            end
            default: begin
                w_nextState = S_FETCH;
            end
        endcase

        // Outputs are forced quiet while reset is held, even mid-instruction.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            PCSource    = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegDst      = 1'b0;
            MemToReg    = 1'b0;
            RegWrite    = 1'b0;
            ALUsrcA     = 1'b0;
            ALUsrcB     = 2'b00;
            ALUOP       = 3'b000;
            instrDone   = 1'b0;
            illegalOp   = 1'b0;
            memTimeout  = 1'b0;
            state       = 4'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_multiciclo.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_multiciclo
// Brief   : Directed vector bench for control_multiciclo (MEM_TIMEOUT = 4).
// Rev     : 1.0  initial release
// ============================================================================
module tb_control_multiciclo;

    logic       clk;
    logic       reset;
    logic [5:0] opCode;
    logic       memReady;
    logic       PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemToReg, RegWrite, ALUsrcA;
    logic [1:0] ALUsrcB;
    logic [2:0] ALUOP;
    logic       instrDone, illegalOp, memTimeout;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    control_multiciclo #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opCode(opCode), .memReady(memReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
        .ALUOP(ALUOP), .instrDone(instrDone), .illegalOp(illegalOp),
        .memTimeout(memTimeout), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,PCSource,IorD,MemRead,MemWrite,IRWrite}, {RegDst,MemToReg,RegWrite},
    // ALUsrcA, ALUsrcB, ALUOP, {instrDone,illegalOp,memTimeout}
    localparam logic [18:0] ZERO     = 19'b0;
    localparam logic [18:0] FETCH_R  = {7'b1000101, 3'b000, 1'b0, 2'b01, 3'b010, 3'b000};
    localparam logic [18:0] FETCH_W  = {7'b0000100, 3'b000, 1'b0, 2'b01, 3'b010, 3'b000};
    localparam logic [18:0] FETCH_TO = {7'b0000100, 3'b000, 1'b0, 2'b01, 3'b010, 3'b001};
    localparam logic [18:0] DECODE   = {7'b0000000, 3'b000, 1'b0, 2'b11, 3'b010, 3'b000};
    localparam logic [18:0] DEC_ILL  = {7'b0000000, 3'b000, 1'b0, 2'b11, 3'b010, 3'b010};
    localparam logic [18:0] EXEC_R   = {7'b0000000, 3'b000, 1'b1, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] EXI_ADD  = {7'b0000000, 3'b000, 1'b1, 2'b10, 3'b010, 3'b000};
    localparam logic [18:0] EXI_SLT  = {7'b0000000, 3'b000, 1'b1, 2'b10, 3'b111, 3'b000};
    localparam logic [18:0] EXI_AND  = {7'b0000000, 3'b000, 1'b1, 2'b10, 3'b011, 3'b000};
    localparam logic [18:0] EXI_OR   = {7'b0000000, 3'b000, 1'b1, 2'b10, 3'b001, 3'b000};
    localparam logic [18:0] MEM_RD   = {7'b0001100, 3'b000, 1'b0, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] MEM_WB   = {7'b0000000, 3'b011, 1'b0, 2'b00, 3'b000, 3'b100};
    localparam logic [18:0] MWR_W    = {7'b0001010, 3'b000, 1'b0, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] MWR_R    = {7'b0001010, 3'b000, 1'b0, 2'b00, 3'b000, 3'b100};
    localparam logic [18:0] MWR_TO   = {7'b0001010, 3'b000, 1'b0, 2'b00, 3'b000, 3'b001};
    localparam logic [18:0] WB_R     = {7'b0000000, 3'b101, 1'b0, 2'b00, 3'b000, 3'b100};
    localparam logic [18:0] WB_I     = {7'b0000000, 3'b001, 1'b0, 2'b00, 3'b000, 3'b100};
    localparam logic [18:0] BRANCH   = {7'b0110000, 3'b000, 1'b1, 2'b00, 3'b110, 3'b100};

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] out;
    } vec_t;

    vec_t vecs[$];

    logic [18:0] w_outs;
    assign w_outs = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                     RegDst, MemToReg, RegWrite, ALUsrcA, ALUsrcB, ALUOP,
                     instrDone, illegalOp, memTimeout};

    task automatic addVec(input logic r, input logic [5:0] o, input logic y,
                          input logic [3:0] s, input logic [18:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = y; v.st = s; v.out = e;
        vecs.push_back(v);
    endtask

    // Drive at the falling edge, compare 1 time unit later (well clear of the rising edge).
    task automatic applyCycle(input string name, input logic r, input logic [5:0] o,
                              input logic y, input logic [3:0] s, input logic [18:0] e);
        @(negedge clk);
        reset = r; opCode = o; memReady = y;
        #1;
        checks++;
        if (state !== s || w_outs !== e) begin
            errors++;
            $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     name, state, w_outs, s, e);
        end
    endtask

    task automatic runLatency(input string name, input logic [5:0] op, input int expCycles);
        int  cyc;
        bit  seen;
        seen = 1'b0;
        cyc  = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            reset = 1'b0; opCode = op; memReady = 1'b1;
            #1;
            if (instrDone) begin
                seen = 1'b1;
                cyc  = n;
            end
        end
        checks++;
        if (!seen || cyc != expCycles) begin
            errors++;
            $display("FAIL latency %s: got %0d cycles (seen=%0d), expected %0d",
                     name, cyc, seen, expCycles);
        end
    endtask

    initial begin
        reset = 1'b1; opCode = 6'b0; memReady = 1'b0;

        // reset
        addVec(1, OP_R,    0, 0, ZERO);
        addVec(1, OP_SW,   1, 0, ZERO);
        // ADDI; opcode changes after DECODE to prove the latched copy is used
        addVec(0, OP_ADDI, 1, 0, FETCH_R);
        addVec(0, OP_ADDI, 1, 1, DECODE);
        addVec(0, OP_SLTI, 1, 3, EXI_ADD);
        addVec(0, OP_SLTI, 1, 8, WB_I);
        // R-type
        addVec(0, OP_R,    1, 0, FETCH_R);
        addVec(0, OP_R,    1, 1, DECODE);
        addVec(0, OP_ADDI, 1, 2, EXEC_R);
        addVec(0, OP_ADDI, 1, 8, WB_R);
        // SLTI / ANDI / ORI
        addVec(0, OP_SLTI, 1, 0, FETCH_R);
        addVec(0, OP_SLTI, 1, 1, DECODE);
        addVec(0, OP_SLTI, 1, 3, EXI_SLT);
        addVec(0, OP_SLTI, 1, 8, WB_I);
        addVec(0, OP_ANDI, 1, 0, FETCH_R);
        addVec(0, OP_ANDI, 1, 1, DECODE);
        addVec(0, OP_ANDI, 1, 3, EXI_AND);
        addVec(0, OP_ANDI, 1, 8, WB_I);
        addVec(0, OP_ORI,  1, 0, FETCH_R);
        addVec(0, OP_ORI,  1, 1, DECODE);
        addVec(0, OP_ORI,  1, 3, EXI_OR);
        addVec(0, OP_ORI,  1, 8, WB_I);
        // LW with 3 wait cycles; ready arrives on the would-be timeout cycle
        addVec(0, OP_LW,   1, 0, FETCH_R);
        addVec(0, OP_LW,   1, 1, DECODE);
        addVec(0, OP_SW,   1, 4, EXI_ADD);
        addVec(0, OP_SW,   0, 5, MEM_RD);
        addVec(0, OP_SW,   0, 5, MEM_RD);
        addVec(0, OP_SW,   0, 5, MEM_RD);
        addVec(0, OP_SW,   1, 5, MEM_RD);
        addVec(0, OP_SW,   1, 6, MEM_WB);
        // SW, ready immediately
        addVec(0, OP_SW,   1, 0, FETCH_R);
        addVec(0, OP_SW,   1, 1, DECODE);
        addVec(0, OP_LW,   1, 4, EXI_ADD);
        addVec(0, OP_LW,   1, 7, MWR_R);
        // BEQ
        addVec(0, OP_BEQ,  1, 0, FETCH_R);
        addVec(0, OP_BEQ,  1, 1, DECODE);
        addVec(0, OP_BEQ,  1, 9, BRANCH);
        // illegal opcode
        addVec(0, OP_BAD,  1, 0, FETCH_R);
        addVec(0, OP_BAD,  1, 1, DEC_ILL);
        addVec(0, OP_ADDI, 0, 0, FETCH_W);
        // SW that times out, then a FETCH that times out
        addVec(0, OP_SW,   1, 0, FETCH_R);
        addVec(0, OP_SW,   1, 1, DECODE);
        addVec(0, OP_SW,   1, 4, EXI_ADD);
        addVec(0, OP_SW,   0, 7, MWR_W);
        addVec(0, OP_SW,   0, 7, MWR_W);
        addVec(0, OP_SW,   0, 7, MWR_W);
        addVec(0, OP_SW,   0, 7, MWR_TO);
        addVec(0, OP_SW,   0, 0, FETCH_W);
        addVec(0, OP_SW,   0, 0, FETCH_W);
        addVec(0, OP_SW,   0, 0, FETCH_W);
        addVec(0, OP_SW,   0, 0, FETCH_TO);
        addVec(0, OP_SW,   0, 0, FETCH_W);

        foreach (vecs[i]) begin
            applyCycle($sformatf("vec[%0d]", i), vecs[i].rst, vecs[i].op, vecs[i].rdy,
                       vecs[i].st, vecs[i].out);
        end

        // End-to-end latency with memReady held high
        runLatency("R",    OP_R,    4);
        runLatency("LW",   OP_LW,   5);
        runLatency("SW",   OP_SW,   4);
        runLatency("BEQ",  OP_BEQ,  3);
        runLatency("ADDI", OP_ADDI, 4);

        // Reset asserted while a store is waiting; counter must restart from 0
        applyCycle("rst_fetch",   0, OP_SW, 1, 0, FETCH_R);
        applyCycle("rst_decode",  0, OP_SW, 1, 1, DECODE);
        applyCycle("rst_addr",    0, OP_SW, 1, 4, EXI_ADD);
        applyCycle("rst_wr0",     0, OP_SW, 0, 7, MWR_W);
        applyCycle("rst_wr1",     0, OP_SW, 0, 7, MWR_W);
        applyCycle("rst_hold0",   1, OP_SW, 0, 0, ZERO);
        applyCycle("rst_hold1",   1, OP_SW, 1, 0, ZERO);
        applyCycle("rst_rel0",    0, OP_SW, 0, 0, FETCH_W);
        applyCycle("rst_rel1",    0, OP_SW, 0, 0, FETCH_W);
        applyCycle("rst_rel2",    0, OP_SW, 0, 0, FETCH_W);
        applyCycle("rst_rel3",    0, OP_SW, 0, 0, FETCH_TO);
        applyCycle("rst_rel4",    0, OP_SW, 1, 0, FETCH_R);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
